// File: rtl/serial_paralelo_rx_if.sv
// serial_paralelo_rx_if: serial input and aligned byte outputs of the receiver
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       idle_out;
  logic       com_out;
  logic       active_out;
  modport master (output data_in, input data_out, valid_out, idle_out, com_out, active_out);
  modport slave (input data_in, output data_out, valid_out, idle_out, com_out, active_out);
endinterface

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: comma-aligned serial-to-parallel receiver
module serial_paralelo_rx #(
  parameter logic [7:0] COM = 8'hBC,
  parameter logic [7:0] IDL = 8'h7C,
  parameter int COM_COUNT = 4
) (
  input  logic clk_32f,
  input  logic reset,
  serial_paralelo_rx_if.slave rx
);
  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;
  localparam logic [3:0] CC = 4'(COM_COUNT);
  state_t     r_state;
  logic [7:0] r_sr;
  logic [7:0] r_data;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_com_cnt;
  logic       r_valid;
  logic       r_idle;
  logic       r_com;
  logic       r_active;
  logic [7:0] w_win;
  logic       w_bnd;
  assign w_win = {r_sr[6:0], rx.data_in};
  assign w_bnd = r_bit_cnt == 3'd7;
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_sr      <= '0;
      r_data    <= '0;
      r_bit_cnt <= '0;
      r_com_cnt <= '0;
      r_valid   <= 1'b0;
      r_idle    <= 1'b0;
      r_com     <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_sr    <= w_win;
      r_valid <= 1'b0;
      r_idle  <= 1'b0;
      r_com   <= 1'b0;
      case (r_state)
        SEARCH: begin
          r_bit_cnt <= '0;
          if (w_win == COM) begin
            r_state   <= CC == 4'd1 ? ACTIVE : ALIGN;
            r_active  <= CC == 4'd1;
            r_com_cnt <= CC == 4'd1 ? 4'd0 : 4'd1;
          end
        end
        ALIGN: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            // a non-comma on a boundary drops alignment; no re-check on this edge
            if (w_win != COM) begin
              r_state   <= SEARCH;
              r_com_cnt <= '0;
            end else if (r_com_cnt + 4'd1 == CC) begin
              r_state   <= ACTIVE;
              r_active  <= 1'b1;
              r_com_cnt <= '0;
            end else begin
              r_com_cnt <= r_com_cnt + 4'd1;
            end
          end
        end
        ACTIVE: begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_bnd) begin
            r_data  <= w_win;
            r_com   <= w_win == COM;
            r_idle  <= w_win == IDL;
            r_valid <= w_win != COM && w_win != IDL;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end
  assign rx.data_out   = r_data;
  assign rx.valid_out  = r_valid;
  assign rx.idle_out   = r_idle;
  assign rx.com_out    = r_com;
  assign rx.active_out = r_active;
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: scoreboard bench for COM_COUNT=4 and COM_COUNT=1 receivers
module tb_serial_paralelo_rx;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] IDL = 8'h7C;
  typedef struct {int e; int k; logic [7:0] d;} ev_t;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  logic pa4 = 1'b0;
  logic pa1 = 1'b0;
  bit stream[$];
  ev_t q4[$];
  ev_t q1[$];
  serial_paralelo_rx_if rx4 ();
  serial_paralelo_rx_if rx1 ();
  assign rx4.data_in = data_in;
  assign rx1.data_in = data_in;
  serial_paralelo_rx #(.COM(COM), .IDL(IDL), .COM_COUNT(4)) dut4 (.clk_32f(clk_32f), .reset(reset), .rx(rx4));
  serial_paralelo_rx #(.COM(COM), .IDL(IDL), .COM_COUNT(1)) dut1 (.clk_32f(clk_32f), .reset(reset), .rx(rx1));
  always #5 clk_32f = ~clk_32f;
  always @(posedge clk_32f) ecnt <= reset ? 0 : ecnt + 1;
  function automatic logic [7:0] get_w(input int k);
    logic [7:0] w = '0;
    for (int j = 0; j < 8; j++) begin
      int idx = k - 7 + j;
      w = {w[6:0], idx >= 1 ? stream[idx-1] : 1'b0};
    end
    return w;
  endfunction
  task automatic push_ev(input int id, input int e, input int k, input logic [7:0] d);
    ev_t x;
    x.e = e; x.k = k; x.d = d;
    if (id == 0) q4.push_back(x); else q1.push_back(x);
  endtask
  // expected events: kind 0 data, 1 idle, 2 comma, 3 active rise
  task automatic model(input int cc, input int id);
    int n = stream.size();
    int k = 1;
    while (k <= n) begin
      if (get_w(k) == COM) begin
        int m = 1;
        int e = k;
        while (m < cc && e + 8 <= n && get_w(e + 8) == COM) begin e += 8; m++; end
        if (m == cc) begin
          push_ev(id, e, 3, 8'h00);
          for (int p = e + 8; p <= n; p += 8) begin
            logic [7:0] w = get_w(p);
            push_ev(id, p, w == COM ? 2 : w == IDL ? 1 : 0, w);
          end
          k = n + 1;
        end else k = (e + 8 <= n) ? e + 9 : n + 1;
      end else k++;
    end
  endtask
  task automatic mon(input int id, input logic v, input logic i, input logic c, input logic a, input logic pa, input logic [7:0] d);
    int n;
    int k;
    ev_t x;
    logic got;
    n = int'(v) + int'(i) + int'(c) + int'(a && !pa);
    if (n == 0) return;
    k = (a && !pa) ? 3 : c ? 2 : i ? 1 : 0;
    checks++;
    got = id == 0 ? q4.size() > 0 : q1.size() > 0;
    if (n > 1 || !got) begin
      failures++;
      $display("FAIL mon%0d edge %0d: %0d events seen (kind %0d), queued=%0d, required exactly one queued event", id, ecnt, n, k, got);
      return;
    end
    if (id == 0) x = q4.pop_front(); else x = q1.pop_front();
    if (x.e != ecnt || x.k != k || (k != 3 && x.d != d)) begin
      failures++;
      $display("FAIL mon%0d event: got edge=%0d kind=%0d data=%h, required edge=%0d kind=%0d data=%h", id, ecnt, k, d, x.e, x.k, x.d);
    end
  endtask
  always @(negedge clk_32f) begin
    mon(0, rx4.valid_out, rx4.idle_out, rx4.com_out, rx4.active_out, pa4, rx4.data_out);
    pa4 = rx4.active_out;
  end
  always @(negedge clk_32f) begin
    mon(1, rx1.valid_out, rx1.idle_out, rx1.com_out, rx1.active_out, pa1, rx1.data_out);
    pa1 = rx1.active_out;
  end
  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) stream.push_back(b[j]);
  endtask
  task automatic push_bits(input int n);
    for (int j = 0; j < n; j++) stream.push_back(1'($urandom_range(0, 1)));
  endtask
  task automatic run_seg();
    reset = 1'b1;
    @(negedge clk_32f);
    reset = 1'b0;
    checks++;
    if ({rx4.data_out, rx4.valid_out, rx4.idle_out, rx4.com_out, rx4.active_out,
         rx1.data_out, rx1.valid_out, rx1.idle_out, rx1.com_out, rx1.active_out} != '0) begin
      failures++;
      $display("FAIL reset_outputs: dut4 d=%h v%b i%b c%b a%b dut1 d=%h v%b i%b c%b a%b, required all 0",
               rx4.data_out, rx4.valid_out, rx4.idle_out, rx4.com_out, rx4.active_out,
               rx1.data_out, rx1.valid_out, rx1.idle_out, rx1.com_out, rx1.active_out);
    end
    model(4, 0);
    model(1, 1);
    foreach (stream[i]) begin
      data_in = stream[i];
      @(negedge clk_32f);
    end
    #2;
    checks += 2;
    if (q4.size() != 0) begin failures++; $display("FAIL missed_events dut4: %0d left, required 0", q4.size()); end
    if (q1.size() != 0) begin failures++; $display("FAIL missed_events dut1: %0d left, required 0", q1.size()); end
    q4.delete();
    q1.delete();
    stream.delete();
  endtask
  initial begin
    repeat (4) push_byte(COM); push_byte(8'h5A);
    run_seg();
    repeat (3) push_byte(COM); push_byte(8'h5A); push_byte(8'h33);
    run_seg();
    stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    repeat (4) push_byte(COM); push_byte(IDL); push_byte(8'h3C);
    run_seg();
    repeat (4) push_byte(COM); push_byte(8'h5A); push_byte(COM); push_byte(8'h11);
    run_seg();
    repeat (4) push_byte(COM); push_byte(8'h5A); stream.push_back(1'b1); stream.push_back(1'b0); stream.push_back(1'b1);
    run_seg();
    repeat (3) push_byte(COM); push_byte(8'h5A);
    run_seg();
    push_byte(COM); push_byte(8'hA5);
    run_seg();
    for (int s = 0; s < 40; s++) begin
      push_bits($urandom_range(0, 10));
      repeat ($urandom_range(1, 5)) push_byte(COM);
      repeat ($urandom_range(0, 6)) begin
        int r = $urandom_range(0, 3);
        push_byte(r == 0 ? COM : r == 1 ? IDL : 8'($urandom));
      end
      push_bits($urandom_range(0, 7));
      run_seg();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
